// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs -- definitions shared by the decode stage and the writeback stage.
//
// Contents:
//   wb_sel_e    : result-select encoding carried down the pipeline
//   F3_*        : RV32I load funct3 codes (width / signedness)
//   wb_entry_t  : contents of the WB pipeline register
// ---------------------------------------------------------------------------
package cpu_defs;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    // Only five of the eight funct3 codes are legal loads. The three
    // unused codes are left out and caught by the default arm of the
    // decoder, so these are plain constants rather than an enum.
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        wb_sel_e     wb_sel;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [31:0] load_word;
        logic [2:0]  funct3;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align -- combinational load-data extraction and extension.
//
// Ports:
//   word    in  32  raw aligned data-memory word
//   addr_lo in   2  low effective-address bits (byte lane; bit 1 = half lane)
//   funct3  in   3  load width/sign code
//   data    out 32  extracted, extended load value (0 when illegal)
//   illegal out  1  funct3 is not a legal load code
//
// Misaligned LH/LW addresses are not flagged: LH takes the half selected by
// addr_lo[1] and LW always returns the whole word.
// ---------------------------------------------------------------------------
module load_align
    import cpu_defs::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        illegal
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LW:   data = word;
            F3_LBU:  data = {24'd0, byte_lane};
            F3_LHU:  data = {16'd0, half_lane};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage -- MEM/WB pipeline register, result select and retirement
// counter.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   mem_*               instruction presented by the MEM stage
//   hold                freeze the WB register
//   flush               replace the WB entry with a bubble (beats hold)
//   rf_we/rf_rd_addr/rf_wdata   register-file write port (rf_wdata also
//                               serves as the forwarding value)
//   wb_valid            WB holds a real instruction
//   wb_load_err         illegal load funct3 retired this cycle
//   instret             64-bit retired-instruction count
//
// A "fresh" bit marks the first cycle an entry sits in WB. Write enable,
// load error and retirement counting are all qualified by it, so an entry
// frozen by hold writes and counts exactly once.
// ---------------------------------------------------------------------------
module writeback_stage
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd_addr,
    input  logic [1:0]  mem_wb_sel,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_pc_plus4,
    input  logic [31:0] mem_load_word,
    input  logic [2:0]  mem_funct3,
    input  logic        hold,
    input  logic        flush,
    output logic        rf_we,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_wdata,
    output logic        wb_valid,
    output logic        wb_load_err,
    output logic [63:0] instret
);

    wb_entry_t   entry_q, entry_d;
    logic        fresh_q, fresh_d;
    logic [63:0] instret_q, instret_d;

    logic [31:0] load_data;
    logic        load_illegal;
    logic        bad_load;

    load_align u_load_align (
        .word    (entry_q.load_word),
        .addr_lo (entry_q.alu_result[1:0]),
        .funct3  (entry_q.funct3),
        .data    (load_data),
        .illegal (load_illegal)
    );

    // Next-state: flush > hold > load. Any cycle that does not load a new
    // instruction leaves fresh clear.
    always_comb begin
        entry_d = entry_q;
        fresh_d = 1'b0;
        if (flush) begin
            entry_d = '0;
        end else if (!hold) begin
            entry_d.valid      = mem_valid;
            entry_d.reg_write  = mem_reg_write;
            entry_d.rd         = mem_rd_addr;
            entry_d.wb_sel     = wb_sel_e'(mem_wb_sel);
            entry_d.alu_result = mem_alu_result;
            entry_d.pc_plus4   = mem_pc_plus4;
            entry_d.load_word  = mem_load_word;
            entry_d.funct3     = mem_funct3;
            fresh_d            = 1'b1;
        end
        // Count on the edge that makes the entry valid and fresh, so the
        // counter already includes it in the cycle rf_we is asserted.
        instret_d = instret_q + {63'd0, entry_d.valid & fresh_d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q   <= '0;
            fresh_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            entry_q   <= entry_d;
            fresh_q   <= fresh_d;
            instret_q <= instret_d;
        end
    end

    assign bad_load = (entry_q.wb_sel == WB_LOAD) & load_illegal;

    always_comb begin
        case (entry_q.wb_sel)
            WB_ALU:  rf_wdata = entry_q.alu_result;
            WB_LOAD: rf_wdata = load_data;   // already 0 for illegal funct3
            WB_PC4:  rf_wdata = entry_q.pc_plus4;
            default: rf_wdata = '0;
        endcase
    end

    assign rf_we       = entry_q.valid & entry_q.reg_write & fresh_q
                       & (entry_q.rd != 5'd0) & ~bad_load;
    assign wb_load_err = entry_q.valid & fresh_q & bad_load;
    assign rf_rd_addr  = entry_q.rd;
    assign wb_valid    = entry_q.valid;
    assign instret     = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// Self-checking bench for writeback_stage: reset, a table of single-entry
// vectors, hold/flush/illegal/wrap/reset-in-hold sequences, then randomized
// traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_pc_plus4;
    logic [31:0] mem_load_word;
    logic [2:0]  mem_funct3;
    logic        hold;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wdata;
    logic        wb_valid;
    logic        wb_load_err;
    logic [63:0] instret;

    int checks   = 0;
    int failures = 0;

    writeback_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd_addr    (mem_rd_addr),
        .mem_wb_sel     (mem_wb_sel),
        .mem_alu_result (mem_alu_result),
        .mem_pc_plus4   (mem_pc_plus4),
        .mem_load_word  (mem_load_word),
        .mem_funct3     (mem_funct3),
        .hold           (hold),
        .flush          (flush),
        .rf_we          (rf_we),
        .rf_rd_addr     (rf_rd_addr),
        .rf_wdata       (rf_wdata),
        .wb_valid       (wb_valid),
        .wb_load_err    (wb_load_err),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    // The model holds "the instruction currently in WB", whether it has
    // already had its one chance to write, and the number retired so far.
    logic        m_valid, m_rw, m_first;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [31:0] m_alu, m_pc4, m_word;
    logic [2:0]  m_f3;
    logic [63:0] m_cnt;

    function automatic void ref_load(input logic [31:0] w, input logic [1:0] a,
                                     input logic [2:0] f3,
                                     output logic [31:0] d, output logic ill);
        logic [31:0]        by_byte, by_half;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        by_byte = w >> (8 * int'(a));
        by_half = w >> (16 * int'(a[1]));
        sb  = by_byte[7:0];
        sh  = by_half[15:0];
        d   = 32'd0;
        ill = 1'b0;
        case (f3)
            3'd0:    d = 32'(sb);
            3'd1:    d = 32'(sh);
            3'd2:    d = w;
            3'd4:    d = {24'd0, by_byte[7:0]};
            3'd5:    d = {16'd0, by_half[15:0]};
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic model_update();
        if (rst) begin
            m_valid = 0; m_rw = 0; m_first = 0; m_rd = 0; m_sel = 0;
            m_alu = 0; m_pc4 = 0; m_word = 0; m_f3 = 0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_first = 0;
        end else if (hold) begin
            m_first = 0;
        end else begin
            m_valid = mem_valid;     m_rw  = mem_reg_write; m_rd   = mem_rd_addr;
            m_sel   = mem_wb_sel;    m_alu = mem_alu_result; m_pc4 = mem_pc_plus4;
            m_word  = mem_load_word; m_f3  = mem_funct3;    m_first = 1;
            if (mem_valid) m_cnt = m_cnt + 64'd1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Update the model from the current inputs, clock, sample 1 ns later.
    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] word,
                         input logic [2:0] f3);
        mem_valid = v; mem_reg_write = rw; mem_rd_addr = rd; mem_wb_sel = sel;
        mem_alu_result = alu; mem_pc_plus4 = pc4; mem_load_word = word; mem_funct3 = f3;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"},      64'(rf_we), 64'd0);
        check({tag, "_rd"},      64'(rf_rd_addr), 64'd0);
        check({tag, "_wdata"},   64'(rf_wdata), 64'd0);
        check({tag, "_valid"},   64'(wb_valid), 64'd0);
        check({tag, "_err"},     64'(wb_load_err), 64'd0);
        check({tag, "_instret"}, instret, 64'd0);
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ld, exp_wdata;
        logic        ill, exp_we, exp_err, is_load;
        ref_load(m_word, m_alu[1:0], m_f3, ld, ill);
        is_load = (m_sel == 2'd1);
        case (m_sel)
            2'd0:    exp_wdata = m_alu;
            2'd1:    exp_wdata = ill ? 32'd0 : ld;
            2'd2:    exp_wdata = m_pc4;
            default: exp_wdata = 32'd0;
        endcase
        exp_we  = m_valid && m_rw && m_first && (m_rd != 0) && !(is_load && ill);
        exp_err = m_valid && m_first && is_load && ill;
        check({tag, "_we"},      64'(rf_we), 64'(exp_we));
        check({tag, "_err"},     64'(wb_load_err), 64'(exp_err));
        check({tag, "_valid"},   64'(wb_valid), 64'(m_valid));
        check({tag, "_instret"}, instret, m_cnt);
        if (m_valid) begin
            check({tag, "_rd"},    64'(rf_rd_addr), 64'(m_rd));
            check({tag, "_wdata"}, 64'(rf_wdata), 64'(exp_wdata));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] word;
        logic [2:0]  f3;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] W = 32'h80FF_7F01;

    initial begin
        logic [63:0] cnt_before;

        vecs = '{
            '{"lb_a3",     1, 1, 5'd3,  2'd1, 32'h0000_1003, 32'h0,   W, 3'd0, 1, 32'hFFFF_FF80, 0},
            '{"lbu_a3",    1, 1, 5'd3,  2'd1, 32'h0000_1003, 32'h0,   W, 3'd4, 1, 32'h0000_0080, 0},
            '{"lh_a2",     1, 1, 5'd4,  2'd1, 32'h0000_1002, 32'h0,   W, 3'd1, 1, 32'hFFFF_80FF, 0},
            '{"lhu_a2",    1, 1, 5'd4,  2'd1, 32'h0000_1002, 32'h0,   W, 3'd5, 1, 32'h0000_80FF, 0},
            '{"lw_a0",     1, 1, 5'd6,  2'd1, 32'h0000_1000, 32'h0,   W, 3'd2, 1, 32'h80FF_7F01, 0},
            '{"lb_a1",     1, 1, 5'd7,  2'd1, 32'h0000_1001, 32'h0,   W, 3'd0, 1, 32'h0000_007F, 0},
            '{"lh_mis_a1", 1, 1, 5'd7,  2'd1, 32'h0000_1001, 32'h0,   W, 3'd1, 1, 32'h0000_7F01, 0},
            '{"lw_mis_a2", 1, 1, 5'd8,  2'd1, 32'h0000_1002, 32'h0,   W, 3'd2, 1, 32'h80FF_7F01, 0},
            '{"ld_f3_7",   1, 1, 5'd9,  2'd1, 32'h0000_1000, 32'h0,   W, 3'd7, 0, 32'h0000_0000, 1},
            '{"ld_f3_3",   1, 1, 5'd9,  2'd1, 32'h0000_1000, 32'h0,   W, 3'd3, 0, 32'h0000_0000, 1},
            '{"ld_f3_6",   1, 1, 5'd9,  2'd1, 32'h0000_1000, 32'h0,   W, 3'd6, 0, 32'h0000_0000, 1},
            '{"pc4",       1, 1, 5'd1,  2'd2, 32'h0000_1000, 32'h400, W, 3'd0, 1, 32'h0000_0400, 0},
            '{"sel_rsvd",  1, 1, 5'd2,  2'd3, 32'hDEAD_BEEF, 32'h400, W, 3'd0, 1, 32'h0000_0000, 0},
            '{"alu_f3_7",  1, 1, 5'd2,  2'd0, 32'hCAFE_0001, 32'h0,   W, 3'd7, 1, 32'hCAFE_0001, 0},
            '{"rd0",       1, 1, 5'd0,  2'd0, 32'h1111_2222, 32'h0,   W, 3'd0, 0, 32'h1111_2222, 0},
            '{"no_rw",     1, 0, 5'd10, 2'd0, 32'h3333_4444, 32'h0,   W, 3'd0, 0, 32'h3333_4444, 0},
            '{"invalid",   0, 1, 5'd11, 2'd0, 32'h5555_6666, 32'h0,   W, 3'd0, 0, 32'h5555_6666, 0}
        };

        // ---- reset ----
        rst = 1; hold = 0; flush = 0;
        drive(1, 1, 5'd7, 2'd0, 32'hFFFF_FFFF, 32'h4, W, 3'd0);
        tick(); tick();
        check_zero("reset");
        rst = 0;

        // ---- simple ALU write ----
        drive(1, 1, 5'd5, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 3'd0);
        tick();
        check("alu_we", 64'(rf_we), 64'd1);
        check("alu_rd", 64'(rf_rd_addr), 64'd5);
        check("alu_wdata", 64'(rf_wdata), 64'h1234);
        check("alu_instret", instret, 64'd1);

        // ---- table ----
        foreach (vecs[i]) begin
            cnt_before = instret;
            drive(vecs[i].v, vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].alu,
                  vecs[i].pc4, vecs[i].word, vecs[i].f3);
            tick();
            check({vecs[i].name, "_we"},    64'(rf_we), 64'(vecs[i].exp_we));
            check({vecs[i].name, "_wdata"}, 64'(rf_wdata), 64'(vecs[i].exp_wdata));
            check({vecs[i].name, "_err"},   64'(wb_load_err), 64'(vecs[i].exp_err));
            check({vecs[i].name, "_valid"}, 64'(wb_valid), 64'(vecs[i].v));
            check({vecs[i].name, "_cnt"},   instret, cnt_before + 64'(vecs[i].v));
        end

        // ---- hold: one write, one count across 3 held cycles ----
        drive(1, 1, 5'd12, 2'd1, 32'h0000_2003, 32'h0, W, 3'd0);
        tick();
        cnt_before = instret;
        check("hold_first_we", 64'(rf_we), 64'd1);
        hold = 1;
        drive(1, 1, 5'd13, 2'd0, 32'h9999_9999, 32'h0, 32'h0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_we", 64'(rf_we), 64'd0);
            check("hold_valid", 64'(wb_valid), 64'd1);
            check("hold_rd", 64'(rf_rd_addr), 64'd12);
            check("hold_wdata", 64'(rf_wdata), 64'hFFFF_FF80);
            check("hold_instret", instret, cnt_before);
        end

        // ---- illegal load held: error only in the fresh cycle ----
        hold = 0;
        drive(1, 1, 5'd14, 2'd1, 32'h0, 32'h0, W, 3'd7);
        tick();
        check("ill_err_fresh", 64'(wb_load_err), 64'd1);
        check("ill_we", 64'(rf_we), 64'd0);
        hold = 1;
        tick();
        check("ill_err_held", 64'(wb_load_err), 64'd0);

        // ---- flush beats hold ----
        hold = 0;
        drive(1, 1, 5'd15, 2'd0, 32'h0000_00AA, 32'h0, 32'h0, 3'd0);
        tick();
        cnt_before = instret;
        hold = 1; flush = 1;
        tick();
        check("flush_valid", 64'(wb_valid), 64'd0);
        check("flush_we", 64'(rf_we), 64'd0);
        check("flush_instret", instret, cnt_before);
        hold = 0; flush = 0;

        // ---- instret wrap ----
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        check("wrap_preset", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 0, 5'd3, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0);
        tick();
        check("wrap_zero", instret, 64'd0);
        tick();
        check("wrap_one", instret, 64'd1);

        // ---- reset in the middle of a hold ----
        drive(1, 1, 5'd9, 2'd2, 32'h0, 32'h0000_0804, 32'h0, 3'd0);
        tick();
        check("rsthold_pre_we", 64'(rf_we), 64'd1);
        hold = 1;
        tick();
        rst = 1;
        tick();
        check_zero("rsthold");
        rst = 0;
        tick();
        check_zero("rsthold_after");
        hold = 0;

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 5) != 0, $urandom_range(0, 4) != 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom), $urandom, $urandom, $urandom, 3'($urandom));
            tick();
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
